// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out stream bundle for imm_gen_pipe.
//   in_valid, in_ready, in_instruction[31:0]        : instruction stream (producer -> block)
//   out_valid, out_ready, out_imm[XLEN-1:0],
//   out_fmt[2:0], out_illegal                       : decoded immediate stream (block -> consumer)
// Modports: master = fetch/consumer side (testbench), slave = imm_gen_pipe.
interface imm_gen_pipe_if #(
   parameter int unsigned XLEN = 64
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instruction;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;

   modport master (
      output in_valid, in_instruction, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal
   );

   modport slave (
      input  in_valid, in_instruction, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator with a 2-entry (output + skid) buffer.
//   clock, reset   : system clock, synchronous active-high reset
//   bus (slave)    : in_valid/in_ready/in_instruction in, out_valid/out_ready/out_imm/
//                    out_fmt/out_illegal out; one instruction per cycle, 1-cycle latency
//   stall_count    : 32-bit saturating count of out_valid && !out_ready cycles,
//                    present only when IMM_GEN_STALL_CNT_EN is defined
// XLEN must be 32 or 64.
module imm_gen_pipe #(
   parameter int unsigned XLEN = 64
) (
   input  logic          clock,
   input  logic          reset,
   imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_STALL_CNT_EN
   ,
   output logic [31:0]   stall_count
`endif
);

   localparam int unsigned FMT_W = 3;
   localparam int unsigned OPC_W = 7;

   localparam logic [FMT_W-1:0] FMT_I    = 3'd0;
   localparam logic [FMT_W-1:0] FMT_S    = 3'd1;
   localparam logic [FMT_W-1:0] FMT_B    = 3'd2;
   localparam logic [FMT_W-1:0] FMT_U    = 3'd3;
   localparam logic [FMT_W-1:0] FMT_J    = 3'd4;
   localparam logic [FMT_W-1:0] FMT_NONE = 3'd5;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
   localparam logic [OPC_W-1:0] OP_IMM32  = 7'b0011011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [FMT_W-1:0] fmt;
      logic             illegal;
   } entry_t;

   entry_t      dec;
   logic [31:0] imm32;
   logic [31:0] inst;

   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   rdy_q, rdy_d;
   logic   accept;

   assign inst = bus.in_instruction;

   // Opcode decode and 32-bit immediate assembly, then sign-extension to XLEN.
   always_comb begin
      imm32       = '0;
      dec         = '0;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
      case (inst[OPC_W-1:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
            imm32       = {{20{inst[31]}}, inst[31:20]};
            dec.fmt     = FMT_I;
            dec.illegal = 1'b0;
         end
         OP_IMM32: begin
            // W-form immediates only exist on RV64.
            if (XLEN == 64) begin
               imm32       = {{20{inst[31]}}, inst[31:20]};
               dec.fmt     = FMT_I;
               dec.illegal = 1'b0;
            end
         end
         OP_STORE: begin
            imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            dec.fmt     = FMT_S;
            dec.illegal = 1'b0;
         end
         OP_BRANCH: begin
            imm32       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            dec.fmt     = FMT_B;
            dec.illegal = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            imm32       = {inst[31:12], 12'b0};
            dec.fmt     = FMT_U;
            dec.illegal = 1'b0;
         end
         OP_JAL: begin
            imm32       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            dec.fmt     = FMT_J;
            dec.illegal = 1'b0;
         end
         default: begin
            imm32 = '0;
         end
      endcase
      dec.imm = XLEN'($signed(imm32));
   end

   // in_ready is a flop, so a full skid is only visible to the producer one cycle later;
   // the skid entry absorbs the instruction accepted in that cycle.
   assign accept = bus.in_valid && rdy_q;

   // Next-state for output register, skid register and ready flop.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (skid_valid_q) begin
         // in_ready is low here, so no new entry can arrive this cycle.
         if (bus.out_ready) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || bus.out_ready) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      rdy_d = !skid_valid_d;
   end

   // Pipeline state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= rdy_d;
      end
   end

   assign bus.in_ready    = rdy_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_fmt     = out_q.fmt;
   assign bus.out_illegal = out_q.illegal;

`ifdef IMM_GEN_STALL_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of cycles the consumer held off a valid output.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid_q && !bus.out_ready && stall_q != 32'hFFFF_FFFF) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven bench for imm_gen_pipe, XLEN=64 and XLEN=32 instances side by side.
module tb_imm_gen_pipe;

   logic clock;
   logic reset;

   imm_gen_pipe_if #(.XLEN(64)) bus64 ();
   imm_gen_pipe_if #(.XLEN(32)) bus32 ();

`ifdef IMM_GEN_STALL_CNT_EN
   logic [31:0] sc64;
   logic [31:0] sc32;
`endif

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clock(clock),
      .reset(reset),
      .bus  (bus64)
`ifdef IMM_GEN_STALL_CNT_EN
      ,
      .stall_count(sc64)
`endif
   );

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clock(clock),
      .reset(reset),
      .bus  (bus32)
`ifdef IMM_GEN_STALL_CNT_EN
      ,
      .stall_count(sc32)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm64;
      logic [2:0]  fmt64;
      logic        ill64;
      logic [31:0] imm32;
      logic [2:0]  fmt32;
      logic        ill32;
   } vec_t;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   localparam int unsigned NVEC = 14;
   vec_t vecs [NVEC];

   exp_t q64[$];
   exp_t q32[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Scoreboard for the 64-bit instance; a stalled output is checked against the head each cycle.
   always @(negedge clock) begin
      if (!reset && bus64.out_valid === 1'b1) begin
         if (q64.size() == 0) begin
            chk("dut64_spurious_out_valid", 64'(bus64.out_valid), 64'd0);
         end else begin
            chk("dut64_imm", bus64.out_imm, q64[0].imm);
            chk("dut64_fmt", 64'(bus64.out_fmt), 64'(q64[0].fmt));
            chk("dut64_illegal", 64'(bus64.out_illegal), 64'(q64[0].ill));
            if (bus64.out_ready) void'(q64.pop_front());
         end
      end
   end

   // Scoreboard for the 32-bit instance.
   always @(negedge clock) begin
      if (!reset && bus32.out_valid === 1'b1) begin
         if (q32.size() == 0) begin
            chk("dut32_spurious_out_valid", 64'(bus32.out_valid), 64'd0);
         end else begin
            chk("dut32_imm", 64'(bus32.out_imm), q32[0].imm);
            chk("dut32_fmt", 64'(bus32.out_fmt), 64'(q32[0].fmt));
            chk("dut32_illegal", 64'(bus32.out_illegal), 64'(q32[0].ill));
            if (bus32.out_ready) void'(q32.pop_front());
         end
      end
   end

   // Offer vecs[idx] (to the 32-bit instance too when use32) until accepted, bounded.
   task automatic send(input int idx, input bit use32);
      bit ok;
      ok = 1'b0;
      bus64.in_valid       = 1'b1;
      bus64.in_instruction = vecs[idx].inst;
      bus32.in_valid       = use32;
      bus32.in_instruction = vecs[idx].inst;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus64.in_ready === 1'b1) begin
            ok = 1'b1;
            q64.push_back('{imm: vecs[idx].imm64, fmt: vecs[idx].fmt64, ill: vecs[idx].ill64});
            if (use32) begin
               chk("dut32_in_ready", 64'(bus32.in_ready), 64'd1);
               q32.push_back('{imm: 64'(vecs[idx].imm32), fmt: vecs[idx].fmt32, ill: vecs[idx].ill32});
            end
         end
         @(posedge clock);
         #1;
         if (ok) break;
      end
      chk("send_accept_timeout", 64'(ok), 64'd1);
      bus64.in_valid = 1'b0;
      bus32.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clock);
         #1;
         if (q64.size() == 0 && q32.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   initial begin
      int t0;
      vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 32'hFFFF_FFFF, 3'd0, 1'b0};
      vecs[1]  = '{32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0, 32'hFFFF_FFFC, 3'd1, 1'b0};
      vecs[2]  = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 32'hFFFF_FFF8, 3'd2, 1'b0};
      vecs[3]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd4, 1'b0, 32'h0000_0800, 3'd4, 1'b0};
      vecs[4]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 32'h8000_0000, 3'd3, 1'b0};
      vecs[5]  = '{32'h0000007F, 64'h0,                   3'd5, 1'b1, 32'h0,         3'd5, 1'b1};
      vecs[6]  = '{32'h0010009B, 64'h0000_0000_0000_0001, 3'd0, 1'b0, 32'h0,         3'd5, 1'b1};
      vecs[7]  = '{32'h12345017, 64'h0000_0000_1234_5000, 3'd3, 1'b0, 32'h1234_5000, 3'd3, 1'b0};
      vecs[8]  = '{32'h7FF00013, 64'h0000_0000_0000_07FF, 3'd0, 1'b0, 32'h0000_07FF, 3'd0, 1'b0};
      vecs[9]  = '{32'h00112423, 64'h0000_0000_0000_0008, 3'd1, 1'b0, 32'h0000_0008, 3'd1, 1'b0};
      vecs[10] = '{32'h00208463, 64'h0000_0000_0000_0008, 3'd2, 1'b0, 32'h0000_0008, 3'd2, 1'b0};
      vecs[11] = '{32'h80000067, 64'hFFFF_FFFF_FFFF_F800, 3'd0, 1'b0, 32'hFFFF_F800, 3'd0, 1'b0};
      vecs[12] = '{32'h00000073, 64'h0,                   3'd0, 1'b0, 32'h0,         3'd0, 1'b0};
      vecs[13] = '{32'h0000003B, 64'h0,                   3'd5, 1'b1, 32'h0,         3'd5, 1'b1};

      reset                = 1'b1;
      bus64.in_valid       = 1'b0;
      bus64.in_instruction = 32'h0;
      bus64.out_ready      = 1'b1;
      bus32.in_valid       = 1'b0;
      bus32.in_instruction = 32'h0;
      bus32.out_ready      = 1'b1;

      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", 64'(bus64.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus64.out_valid), 64'd0);
      chk("rst_out_imm", bus64.out_imm, 64'd0);
      chk("rst_out_fmt", 64'(bus64.out_fmt), 64'd0);
      chk("rst_out_illegal", 64'(bus64.out_illegal), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("post_rst_in_ready", 64'(bus64.in_ready), 64'd1);
      chk("post_rst_in_ready32", 64'(bus32.in_ready), 64'd1);
      @(posedge clock);
      #1;

      // in_instruction must be ignored while in_valid is low.
      bus64.in_instruction = 32'hFFF00093;
      bus32.in_instruction = 32'hFFF00093;
      repeat (3) begin
         @(negedge clock);
         chk("idle_out_valid", 64'(bus64.out_valid), 64'd0);
         @(posedge clock);
         #1;
      end

      // Single addi: result valid one cycle after acceptance.
      send(0, 1'b1);
      @(negedge clock);
      chk("latency_out_valid", 64'(bus64.out_valid), 64'd1);
      chk("latency_out_valid32", 64'(bus32.out_valid), 64'd1);
      drain();

      // Whole table back-to-back: one accept per cycle, results in order.
      t0 = cyc;
      for (int i = 0; i < int'(NVEC); i++) send(i, 1'b1);
      chk("stream_cycles", 64'(cyc - t0), 64'(NVEC));
      @(negedge clock);
      chk("stream_last_out_valid", 64'(bus64.out_valid), 64'd1);
      drain();

      // Backpressure: two accepted, third held while in_ready is low.
      bus64.out_ready = 1'b0;
      send(1, 1'b0);
      send(2, 1'b0);
      bus64.in_valid       = 1'b1;
      bus64.in_instruction = vecs[3].inst;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("bp_in_ready_low", 64'(bus64.in_ready), 64'd0);
         chk("bp_out_valid_held", 64'(bus64.out_valid), 64'd1);
         @(posedge clock);
         #1;
      end
      chk("bp_queue_depth", 64'(q64.size()), 64'd2);
      bus64.out_ready = 1'b1;
      send(3, 1'b0);
      drain();
`ifdef IMM_GEN_STALL_CNT_EN
      chk("stall_count64", 64'(sc64), 64'd5);
      chk("stall_count32", 64'(sc32), 64'd0);
`endif

      // Reset with both buffers full: nothing stale may emerge afterwards.
      bus64.out_ready = 1'b0;
      send(7, 1'b0);
      send(8, 1'b0);
      @(negedge clock);
      chk("fill_in_ready_low", 64'(bus64.in_ready), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      q64.delete();
      q32.delete();
      #1;
      reset           = 1'b0;
      bus64.out_ready = 1'b1;
      @(negedge clock);
      chk("mid_rst_out_valid", 64'(bus64.out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(bus64.in_ready), 64'd0);
      chk("mid_rst_out_imm", bus64.out_imm, 64'd0);
      chk("mid_rst_out_fmt", 64'(bus64.out_fmt), 64'd0);
`ifdef IMM_GEN_STALL_CNT_EN
      chk("mid_rst_stall_count", 64'(sc64), 64'd0);
`endif
      @(negedge clock);
      chk("mid_rst_in_ready_after", 64'(bus64.in_ready), 64'd1);
      repeat (3) begin
         @(negedge clock);
         chk("mid_rst_no_stale", 64'(bus64.out_valid), 64'd0);
      end

      // Traffic resumes normally after the mid-run reset.
      @(posedge clock);
      #1;
      send(4, 1'b1);
      send(6, 1'b1);
      drain();

      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
